sqr_iterative: RTL and testbench

- Sequential integer squarer; the inverse of the pipelined square-root unit.
- Takes an unsigned root and remainder and reconstructs radicand = root*root + remainder.
- Uses one shift-add step per cycle, with valid/ready handshakes on both sides.
- Used to check square-root results in the datapath and to rebuild magnitudes downstream of the root extractor.

---
 rtl/sqrt_pkg.sv | 24 ++
 rtl/sqr_iterative_step.sv | 29 ++
 rtl/sqr_iterative.sv | 114 +++++++++++
 tb/tb_sqr_iterative.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root / squarer datapath.
// State encodings for the iterative squarer and a clog2 helper.
package sqrt_pkg;

   typedef enum logic [1:0] {
      SQR_IDLE = 2'd0,
      SQR_CALC = 2'd1,
      SQR_DONE = 2'd2
   } sqr_state_t;

   // ceil(log2(v)); returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      int t;
      r = 0;
      t = 1;
      while (t < v) begin
         t = t * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sqr_iterative_step.sv
// One shift-add step of the iterative squarer (combinational).
// acc, root_q, cnt in; acc_nxt = acc + (root_q << cnt) if root_q[cnt].
module sqr_step #(
   parameter int WIDTH_ROOT = 8,
   parameter int WIDTH_SQ   = 2 * WIDTH_ROOT,
   parameter int CW         = 3
) (
   input  logic [WIDTH_SQ-1:0]   acc,
   input  logic [WIDTH_ROOT-1:0] root_q,
   input  logic [CW-1:0]         cnt,
   output logic [WIDTH_SQ-1:0]   acc_nxt
);

   logic [WIDTH_SQ-1:0] root_ext;
   logic [WIDTH_SQ-1:0] shifted;
   logic [WIDTH_SQ-1:0] probe;

   // Bit test done by right shift so cnt may be
   // wider than a direct index into root_q.
   always_comb begin
      root_ext = WIDTH_SQ'(root_q);
      shifted  = root_ext << cnt;
      probe    = root_ext >> cnt;
      acc_nxt  = acc;
      if (probe[0])
         acc_nxt = acc + shifted;
   end

endmodule

// File: rtl/sqr_iterative.sv
// Iterative squarer: square = root*root + remainder, one bit/cycle.
// Ports: clk, rst_n, in_valid/in_ready, root, remainder,
// out_valid/out_ready, square, overflow (remainder > 2*root).
module sqr_iterative
   import sqrt_pkg::*;
#(
   parameter int WIDTH_ROOT = 8,
   parameter int WIDTH_REM  = WIDTH_ROOT + 1,
   parameter int WIDTH_SQ   = 2 * WIDTH_ROOT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH_ROOT-1:0] root,
   input  logic [WIDTH_REM-1:0]  remainder,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH_SQ-1:0]   square,
   output logic                  overflow
);

   localparam int CL = clog2(WIDTH_ROOT);
   localparam int CW = (CL < 1) ? 1 : CL;
   localparam logic [CW-1:0] LAST = CW'(WIDTH_ROOT - 1);

   sqr_state_t            state;
   logic [WIDTH_ROOT-1:0] root_q;
   logic [WIDTH_SQ-1:0]   acc;
   logic [WIDTH_SQ-1:0]   acc_nxt;
   logic [CW-1:0]         cnt;
   logic                  ovf_q;
   logic                  accept;
   logic                  ovf_in;
   logic [WIDTH_SQ-1:0]   rem_ext;

   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         SQR_IDLE: in_ready = 1'b1;
         SQR_DONE: in_ready = out_ready;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept  = in_valid && in_ready;
   assign ovf_in  = remainder > {root, 1'b0};
   assign rem_ext = WIDTH_SQ'(remainder);

   sqr_step #(
      .WIDTH_ROOT (WIDTH_ROOT),
      .WIDTH_SQ   (WIDTH_SQ),
      .CW         (CW)
   ) u_step (
      .acc     (acc),
      .root_q  (root_q),
      .cnt     (cnt),
      .acc_nxt (acc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SQR_IDLE;
         root_q    <= '0;
         acc       <= '0;
         cnt       <= '0;
         ovf_q     <= 1'b0;
         square    <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            SQR_IDLE: begin
               if (accept) begin
                  root_q <= root;
                  acc    <= rem_ext;
                  ovf_q  <= ovf_in;
                  cnt    <= '0;
                  state  <= SQR_CALC;
               end
            end
            SQR_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  square    <= acc_nxt;
                  overflow  <= ovf_q;
                  out_valid <= 1'b1;
                  state     <= SQR_DONE;
               end
            end
            SQR_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     root_q <= root;
                     acc    <= rem_ext;
                     ovf_q  <= ovf_in;
                     cnt    <= '0;
                     state  <= SQR_CALC;
                  end else begin
                     state <= SQR_IDLE;
                  end
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= SQR_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqr_iterative.sv
// Self-checking bench for sqr_iterative (WIDTH_ROOT = 8).
// Random and directed operands against an arithmetic model.
module tb_sqr_iterative;

   localparam int W = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     root;
   logic [W:0]       remainder;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   square;
   logic             overflow;

   int tests;
   int fails;

   sqr_iterative #(.WIDTH_ROOT(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .root      (root),
      .remainder (remainder),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .square    (square),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned model_sq(input int unsigned r,
                                            input int unsigned m);
      return (r * r + m) % 65536;
   endfunction

   function automatic bit model_ovf(input int unsigned r,
                                    input int unsigned m);
      return m > 2 * r;
   endfunction

   function automatic int unsigned isqrt(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((r + 1) * (r + 1) <= v)
         r = r + 1;
      return r;
   endfunction

   // Stimulus only: launch one op from IDLE, wait for the result,
   // consume it. Called just after a posedge.
   task automatic do_op(input int unsigned r, input int unsigned m,
                        output int unsigned sq, output bit ovf,
                        output int lat, output bit to);
      int n;
      to = 1'b0;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      in_valid  = 1'b1;
      root      = W'(r);
      remainder = (W+1)'(m);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
         if (lat > 50) begin
            to = 1'b1;
            break;
         end
      end
      sq  = square;
      ovf = overflow;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      root      = '0;
      remainder = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || square !== '0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b sq=%0d ovf=%b want 0 0 0",
                  out_valid, square, overflow);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      int unsigned rs [6] = '{12, 255, 0, 2, 255, 1};
      int unsigned ms [6] = '{0, 510, 0, 5, 511, 2};
      int unsigned sq;
      bit ovf;
      bit to;
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(rs[i], ms[i], sq, ovf, lat, to);
         tests++;
         if (to || lat != W) begin
            fails++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d",
                     i, lat, W);
         end
         tests++;
         if (sq != model_sq(rs[i], ms[i]) ||
             ovf != model_ovf(rs[i], ms[i])) begin
            fails++;
            $display("FAIL directed_result[%0d] r=%0d m=%0d: got %0d/%b want %0d/%b",
                     i, rs[i], ms[i], sq, ovf,
                     model_sq(rs[i], ms[i]), model_ovf(rs[i], ms[i]));
         end
      end
   endtask

   task automatic test_random();
      int unsigned r;
      int unsigned m;
      int unsigned sq;
      bit ovf;
      bit to;
      int lat;
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(255, 0);
         m = (i % 2 == 0) ? $urandom_range(2 * r, 0)
                          : $urandom_range(511, 0);
         do_op(r, m, sq, ovf, lat, to);
         tests++;
         if (to || lat != W || sq != model_sq(r, m) ||
             ovf != model_ovf(r, m)) begin
            fails++;
            $display("FAIL random r=%0d m=%0d: got %0d/%b lat %0d want %0d/%b lat %0d",
                     r, m, sq, ovf, lat, model_sq(r, m), model_ovf(r, m), W);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      int lat;
      in_valid  = 1'b1;
      root      = 8'd20;
      remainder = 9'd5;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (out_valid || n > 50) break;
         n++;
      end
      tests++;
      if (!out_valid) begin
         fails++;
         $display("FAIL bp_first_result: timed out");
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || square !== 16'd405 ||
             overflow !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_stall[%0d]: got v=%b sq=%0d ovf=%b rdy=%b want 1 405 0 0",
                     i, out_valid, square, overflow, in_ready);
         end
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      root      = 8'd3;
      remainder = 9'd1;
      out_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || square !== 16'd405) begin
         fails++;
         $display("FAIL bp_handshake: got rdy=%b sq=%0d want 1 405",
                  in_ready, square);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lat = 0;
      forever begin
         @(negedge clk);
         if (out_valid || lat > 50) break;
         lat++;
      end
      tests++;
      if (lat != W || square !== 16'd10 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL bp_next: got lat %0d sq=%0d ovf=%b want %0d 10 0",
                  lat, square, overflow, W);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int unsigned sq;
      bit ovf;
      bit to;
      int lat;
      in_valid  = 1'b1;
      root      = 8'd200;
      remainder = 9'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || square !== '0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got v=%b sq=%0d ovf=%b want 0 0 0",
                  out_valid, square, overflow);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_idle: got rdy=%b v=%b want 1 0",
                  in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      do_op(7, 3, sq, ovf, lat, to);
      tests++;
      if (to || lat != W || sq != 52 || ovf != 1'b0) begin
         fails++;
         $display("FAIL reset_mid_next: got %0d/%b lat %0d want 52/0 lat %0d",
                  sq, ovf, lat, W);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned rs [4];
      int unsigned ms [4];
      int idx;
      int oidx;
      int cyc;
      int last;
      bit hs;
      for (int i = 0; i < 4; i++) begin
         rs[i] = $urandom_range(255, 0);
         ms[i] = $urandom_range(511, 0);
      end
      idx  = 0;
      oidx = 0;
      cyc  = 0;
      last = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      root      = W'(rs[0]);
      remainder = 9'(ms[0]);
      while (oidx < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         hs = in_valid && in_ready;
         if (out_valid) begin
            tests++;
            if (square != model_sq(rs[oidx], ms[oidx]) ||
                overflow != model_ovf(rs[oidx], ms[oidx])) begin
               fails++;
               $display("FAIL b2b_result[%0d]: got %0d/%b want %0d/%b",
                        oidx, square, overflow,
                        model_sq(rs[oidx], ms[oidx]),
                        model_ovf(rs[oidx], ms[oidx]));
            end
            if (oidx > 0) begin
               tests++;
               if (cyc - last != W + 1) begin
                  fails++;
                  $display("FAIL b2b_interval[%0d]: got %0d want %0d",
                           oidx, cyc - last, W + 1);
               end
            end
            last = cyc;
            oidx++;
         end
         @(posedge clk);
         #1;
         if (hs) begin
            idx++;
            if (idx < 4) begin
               root      = W'(rs[idx]);
               remainder = 9'(ms[idx]);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      tests++;
      if (oidx != 4) begin
         fails++;
         $display("FAIL b2b_count: got %0d results want 4", oidx);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_loopback();
      int unsigned rad;
      int unsigned r;
      int unsigned sq;
      bit ovf;
      bit to;
      int lat;
      for (int i = 0; i < 1002; i++) begin
         if (i == 0)
            rad = 0;
         else if (i == 1)
            rad = 16'hFFFF;
         else
            rad = $urandom_range(65535, 0);
         r = isqrt(rad);
         do_op(r, rad - r * r, sq, ovf, lat, to);
         tests++;
         if (to || sq != rad || ovf != 1'b0) begin
            fails++;
            $display("FAIL loopback R=%0d r=%0d: got %0d/%b want %0d/0",
                     rad, r, sq, ovf, rad);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_loopback();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
